snoop_issuer: RTL and testbench

SNOOP_ISSUER -- requirements
Module: snoop_issuer

---
 rtl/snoop_if.sv | 67 ++++++
 rtl/snoop_issuer.sv | 151 +++++++++++++++
 tb/tb_snoop_issuer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/snoop_if.sv
`default_nettype none
// ============================================================================
// Module      : snoop_if
// Description : Request, AC/CR/CD snoop channels and response bundle for
//               snoop_issuer.
// Revision    : 1.0 - initial release
// ============================================================================
interface snoop_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int CD_BEATS   = 4
);
    logic                           req_valid;
    logic                           req_ready;
    logic [ADDR_WIDTH-1:0]          req_addr;
    logic                           req_unique;

    logic                           ac_valid;
    logic                           ac_ready;
    logic [ADDR_WIDTH-1:0]          ac_addr;
    logic [3:0]                     ac_snoop;
    logic [2:0]                     ac_prot;

    logic                           cr_valid;
    logic                           cr_ready;
    logic [4:0]                     cr_resp;

    logic                           cd_valid;
    logic                           cd_ready;
    logic [DATA_WIDTH-1:0]          cd_data;
    logic                           cd_last;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic                           rsp_data_xfer;
    logic                           rsp_dirty;
    logic                           rsp_shared;
    logic                           rsp_err;
    logic [CD_BEATS*DATA_WIDTH-1:0] rsp_line;

    modport master (
        input  req_valid, req_addr, req_unique,
        output req_ready,
        output ac_valid, ac_addr, ac_snoop, ac_prot,
        input  ac_ready,
        input  cr_valid, cr_resp,
        output cr_ready,
        input  cd_valid, cd_data, cd_last,
        output cd_ready,
        output rsp_valid, rsp_data_xfer, rsp_dirty, rsp_shared, rsp_err, rsp_line,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_addr, req_unique,
        input  req_ready,
        input  ac_valid, ac_addr, ac_snoop, ac_prot,
        output ac_ready,
        output cr_valid, cr_resp,
        input  cr_ready,
        output cd_valid, cd_data, cd_last,
        input  cd_ready,
        input  rsp_valid, rsp_data_xfer, rsp_dirty, rsp_shared, rsp_err, rsp_line,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/snoop_issuer.sv
`default_nettype none
// ============================================================================
// Module      : snoop_issuer
// Description : Issues one ReadClean/ReadUnique snoop at a time and collects
//               the snoop response and optional cache-line data.
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_issuer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int CD_BEATS   = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    snoop_if.master   bus
);
    localparam int                CNT_W       = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(CD_BEATS - 1);
    localparam logic [3:0]        C_SNP_UNIQUE = 4'b0111;
    localparam logic [3:0]        C_SNP_CLEAN  = 4'b0010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_AC = 3'd1,
        WAIT_CR = 3'd2,
        RECV_CD = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_unique;
    logic [3:0]            r_resp;
    logic                  r_proto_err;
    logic [CNT_W-1:0]      r_cnt;

    logic w_req_ready;
    logic w_ac_valid;
    logic w_cr_ready;
    logic w_cd_ready;
    logic w_rsp_valid;
    logic w_req_fire;
    logic w_cr_fire;
    logic w_cd_fire;
    logic w_last_beat;

    assign w_req_fire  = (r_state == IDLE)    && bus.req_valid;
    assign w_cr_fire   = (r_state == WAIT_CR) && bus.cr_valid;
    assign w_cd_fire   = (r_state == RECV_CD) && bus.cd_valid;
    assign w_last_beat = (r_cnt == C_LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_ac_valid  = 1'b0;
        w_cr_ready  = 1'b0;
        w_cd_ready  = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset is folded in so no handshake is offered while it is held.
                w_req_ready = !reset;
                if (bus.req_valid) w_state_nxt = SEND_AC;
            end
            SEND_AC: begin
                w_ac_valid = 1'b1;
                if (bus.ac_ready) w_state_nxt = WAIT_CR;
            end
            WAIT_CR: begin
                w_cr_ready = 1'b1;
                if (bus.cr_valid) w_state_nxt = bus.cr_resp[0] ? RECV_CD : RESP;
            end
            RECV_CD: begin
                w_cd_ready = 1'b1;
                if (bus.cd_valid && (w_last_beat || bus.cd_last)) w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_unique    <= 1'b0;
            r_resp      <= '0;
            r_proto_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_req_fire) begin
                r_addr      <= bus.req_addr;
                r_unique    <= bus.req_unique;
                r_proto_err <= 1'b0;
            end
            if (w_cr_fire) begin
                r_resp <= bus.cr_resp[3:0];
                r_cnt  <= '0;
            end
            if (w_cd_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // Missing last on the final beat, or last arriving early, is a protocol error.
                if (w_last_beat) begin
                    r_proto_err <= !bus.cd_last;
                end else if (bus.cd_last) begin
                    r_proto_err <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < CD_BEATS; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_word <= '0;
            end else if (w_cd_fire && (r_cnt == CNT_W'(gi))) begin
                r_word <= bus.cd_data;
            end
        end

        assign bus.rsp_line[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.ac_valid      = w_ac_valid;
    assign bus.ac_addr       = r_addr;
    assign bus.ac_snoop      = w_ac_valid ? (r_unique ? C_SNP_UNIQUE : C_SNP_CLEAN) : 4'b0000;
    assign bus.ac_prot       = 3'b000;
    assign bus.cr_ready      = w_cr_ready;
    assign bus.cd_ready      = w_cd_ready;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_data_xfer = r_resp[0];
    assign bus.rsp_err       = r_resp[1] | r_proto_err;
    assign bus.rsp_dirty     = r_resp[0] & r_resp[2];
    assign bus.rsp_shared    = r_resp[0] & r_resp[3];

endmodule
`default_nettype wire

// File: tb/tb_snoop_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_issuer
// Description : Self-checking bench for snoop_issuer with a line/flag model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_issuer;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snoop_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CD_BEATS(NB)) bus ();

    snoop_issuer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CD_BEATS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_line   [NB];
    logic [DW-1:0] tx_words [NB];

    task automatic check(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*DW-1:0] model_line();
        logic [NB*DW-1:0] v;
        for (int i = 0; i < NB; i++) v[i*DW +: DW] = m_line[i];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 0; bus.req_addr = '0; bus.req_unique = 0;
        bus.ac_ready  = 0;
        bus.cr_valid  = 0; bus.cr_resp  = '0;
        bus.cd_valid  = 0; bus.cd_data  = '0; bus.cd_last = 0;
        bus.rsp_ready = 0;
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_ac_valid",  bus.ac_valid, 0);
        check("rst_cr_ready",  bus.cr_ready, 0);
        check("rst_cd_ready",  bus.cd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ac_addr",   bus.ac_addr, 0);
        check("rst_ac_snoop",  bus.ac_snoop, 0);
        check("rst_ac_prot",   bus.ac_prot, 0);
        check("rst_flags",     {bus.rsp_data_xfer, bus.rsp_dirty, bus.rsp_shared, bus.rsp_err}, 0);
        check("rst_line",      bus.rsp_line, 0);
    endtask

    // Apply reset for two cycles from a negedge; model line returns to zero.
    task automatic pulse_reset();
        idle_inputs();
        reset = 1;
        #1;
        check_reset_state();
        for (int i = 0; i < NB; i++) m_line[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 0;
        #1;
        check("post_rst_req_ready", bus.req_ready, 1);
    endtask

    // Caller is at a negedge (or just after) with the DUT idle.
    // last_pos: beat index carrying cd_last (NB = never). rst_beat: reset after that beat (-1 none).
    task automatic run_txn(input logic [AW-1:0] addr, input logic uniq, input logic [4:0] cr,
                           input int ac_wait, input int last_pos, input bit gaps,
                           input int rsp_wait, input bit hold_req, input int rst_beat);
        logic [3:0] e_snoop;
        logic       e_err;
        bit         last;
        e_snoop = uniq ? 4'b0111 : 4'b0010;

        bus.req_valid = 1; bus.req_addr = addr; bus.req_unique = uniq;
        check("req_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 0; bus.req_addr = AW'($urandom); bus.req_unique = 1'($urandom);

        for (int i = 0; i <= ac_wait; i++) begin
            check("ac_valid", bus.ac_valid, 1);
            check("ac_addr",  bus.ac_addr, addr);
            check("ac_snoop", bus.ac_snoop, e_snoop);
            check("ac_prot",  bus.ac_prot, 0);
            check("ac_cr_ready", bus.cr_ready, 0);
            if (i < ac_wait) begin
                bus.ac_ready = 0;
                bus.cr_valid = 1'($urandom); bus.cr_resp = 5'($urandom);
                bus.cd_valid = 1'($urandom); bus.cd_data = {$urandom, $urandom};
            end else begin
                bus.ac_ready = 1; bus.cr_valid = 0; bus.cd_valid = 0;
            end
            @(negedge clk);
        end
        bus.ac_ready = 0;
        check("ac_done", bus.ac_valid, 0);
        check("cr_ready", bus.cr_ready, 1);

        if (gaps) begin
            bus.cd_valid = 1; bus.cd_data = {$urandom, $urandom}; bus.cd_last = 1;
            @(negedge clk);
            bus.cd_valid = 0; bus.cd_last = 0;
            check("cr_ready_hold", bus.cr_ready, 1);
        end

        bus.cr_valid = 1; bus.cr_resp = cr;
        @(negedge clk);
        bus.cr_valid = 0;
        e_err = cr[1];

        if (cr[0]) begin
            for (int k = 0; k < NB; k++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        check("cd_ready_gap", bus.cd_ready, 1);
                        bus.cr_valid = 1; bus.cr_resp = 5'($urandom);
                        @(negedge clk);
                        bus.cr_valid = 0;
                    end
                end
                check("cd_ready", bus.cd_ready, 1);
                last = (k == last_pos);
                bus.cd_valid = 1; bus.cd_data = tx_words[k]; bus.cd_last = last;
                @(negedge clk);
                bus.cd_valid = 0; bus.cd_last = 0;
                m_line[k] = tx_words[k];
                if (k == rst_beat) begin
                    pulse_reset();
                    return;
                end
                if (k == NB - 1) begin
                    if (!last) e_err = 1;
                    break;
                end else if (last) begin
                    e_err = 1;
                    break;
                end
            end
        end

        for (int i = 0; i <= rsp_wait; i++) begin
            check("rsp_valid",     bus.rsp_valid, 1);
            check("rsp_data_xfer", bus.rsp_data_xfer, cr[0]);
            check("rsp_err",       bus.rsp_err, e_err);
            check("rsp_dirty",     bus.rsp_dirty, cr[0] & cr[2]);
            check("rsp_shared",    bus.rsp_shared, cr[0] & cr[3]);
            check("rsp_line",      bus.rsp_line, model_line());
            check("rsp_req_ready", bus.req_ready, 0);
            if (hold_req) begin
                bus.req_valid = 1; bus.req_addr = AW'($urandom);
            end
            bus.rsp_ready = (i == rsp_wait);
            @(negedge clk);
        end
        bus.rsp_ready = 0; bus.req_valid = 0;
        check("rsp_done", bus.rsp_valid, 0);
        check("idle_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < NB; i++) m_line[i] = '0;
        reset = 1;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 0;
        #1;
        check("first_req_ready", bus.req_ready, 1);
        @(negedge clk);

        // ReadClean without data
        run_txn(32'h0000_1040, 0, 5'b00000, 0, NB - 1, 0, 0, 0, -1);
        // ReadUnique with ac_ready held low for 3 cycles
        run_txn(32'h0000_2000, 1, 5'b00000, 3, NB - 1, 0, 0, 0, -1);
        // Full line with gaps, dirty and shared
        for (int k = 0; k < NB; k++) tx_words[k] = {16{4'(k + 1)}};
        run_txn(32'h0000_3000, 0, 5'b01101, 0, NB - 1, 1, 0, 0, -1);
        // Early last on beat 2
        for (int k = 0; k < NB; k++) tx_words[k] = {16{4'(k + 10)}};
        run_txn(32'h0000_4000, 0, 5'b00001, 1, 1, 0, 1, 0, -1);
        // Reset after the first data beat, then a normal transaction
        run_txn(32'h0000_5000, 1, 5'b00001, 0, NB - 1, 0, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < NB; k++) tx_words[k] = {$urandom, $urandom};
        run_txn(32'h0000_6000, 0, 5'b00001, 0, NB - 1, 0, 0, 0, -1);
        // Response stalled 5 cycles with req_valid held, back-to-back follow-up
        run_txn(32'h0000_7000, 1, 5'b00000, 0, NB - 1, 0, 5, 1, -1);
        run_txn(32'h0000_8000, 0, 5'b00000, 0, NB - 1, 0, 0, 0, -1);

        for (int t = 0; t < 60; t++) begin
            int rb;
            for (int k = 0; k < NB; k++) tx_words[k] = {$urandom, $urandom};
            rb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NB - 2)) : -1;
            run_txn(AW'($urandom), 1'($urandom), 5'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, NB), 1'($urandom), $urandom_range(0, 3),
                    1'($urandom), rb);
            if (rb >= 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
